// File: rtl/cpu_trace_pkg.sv
// Shared types for the CPU trace buffer: capture FSM states and the 96-bit trace entry.
package cpu_trace_pkg;

  localparam int TRACE_W = 96;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } trace_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] result;
  } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Circular trace store, first-word fall-through. Latency: push visible the cycle after the edge.
// Backpressure: a push into a full buffer is dropped (pulsed on dropped); a same-cycle pop frees no room.
module trace_fifo
  import cpu_trace_pkg::*;
#(
  parameter int  DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  trace_entry_t din,
  output trace_entry_t dout,
  output logic [AW:0]  count,
  output logic         full,
  output logic         empty,
  output logic         dropped
);

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [TRACE_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [AW:0]        r_count;
  logic               w_push_ok;
  logic               w_pop_ok;

  assign full      = (r_count == FULL_CNT);
  assign empty     = (r_count == '0);
  assign w_push_ok = push && !full && !flush;
  assign w_pop_ok  = pop && !empty && !flush;
  assign dropped   = push && full;
  assign count     = r_count;

  // Storage has no reset; the head is gated to zero whenever nothing is held.
  assign dout = empty ? '0 : trace_entry_t'(r_mem[r_rd_ptr]);

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/cpu_trace_capture.sv
// Records one entry per new CPU instruction, stops on an optional PC breakpoint, drains via valid/ready.
// Latency: sample at edge N readable after N. Backpressure: rd_ready stalls the head; full buffer drops and sets overflow.
module cpu_trace_capture
  import cpu_trace_pkg::*;
#(
  parameter int  DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   current_PC,
  input  logic [31:0]   instruction_out,
  input  logic [31:0]   ALU_result_out,
  input  logic          start,
  input  logic          stop_en,
  input  logic [31:0]   stop_pc,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [31:0]   rd_pc,
  output logic [31:0]   rd_instr,
  output logic [31:0]   rd_result,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic [1:0]    state
);

  trace_state_e r_state;
  logic [31:0]  r_last_pc;
  logic         r_first;
  logic         r_overflow;

  logic         w_new;
  logic         w_push;
  logic         w_hit;
  logic         w_flush;
  logic         w_empty;
  logic         w_dropped;
  logic         w_unused_full;
  logic [AW:0]  w_count;
  trace_entry_t w_din;
  trace_entry_t w_dout;

  assign w_new   = r_first || (current_PC != r_last_pc);
  assign w_push  = (r_state == ST_CAPTURE) && w_new;
  assign w_hit   = w_push && stop_en && (current_PC == stop_pc);
  // start is only honoured outside CAPTURE, so a flush never races a push.
  assign w_flush = start && (r_state != ST_CAPTURE);

  assign w_din = '{pc: current_PC, instr: instruction_out, result: ALU_result_out};

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (w_push),
    .pop     (rd_ready),
    .flush   (w_flush),
    .din     (w_din),
    .dout    (w_dout),
    .count   (w_count),
    .full    (w_unused_full),
    .empty   (w_empty),
    .dropped (w_dropped)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_last_pc  <= '0;
      r_first    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state    <= ST_CAPTURE;
            r_first    <= 1'b1;
            r_overflow <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          if (w_push) begin
            r_last_pc <= current_PC;
            r_first   <= 1'b0;
          end
          if (w_dropped) r_overflow <= 1'b1;
          if (w_hit)     r_state    <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (start) begin
            r_state    <= ST_CAPTURE;
            r_first    <= 1'b1;
            r_overflow <= 1'b0;
          end else if (w_count == '0) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rd_valid  = !w_empty;
  assign rd_pc     = w_dout.pc;
  assign rd_instr  = w_dout.instr;
  assign rd_result = w_dout.result;
  assign count     = w_count;
  assign overflow  = r_overflow;
  assign state     = r_state;

endmodule

// File: tb/tb_cpu_trace_capture.sv
// Directed bench for cpu_trace_capture: reset, capture, breakpoint, overflow, streaming, async reset.
module tb_cpu_trace_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] current_PC, instruction_out, ALU_result_out;
  logic        start, stop_en, rd_ready;
  logic [31:0] stop_pc;
  logic        rd_valid, overflow;
  logic [31:0] rd_pc, rd_instr, rd_result;
  logic [4:0]  count;
  logic [1:0]  state;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cpu_trace_capture #(.DEPTH(16)) dut (
    .clk(clk), .reset(reset),
    .current_PC(current_PC), .instruction_out(instruction_out), .ALU_result_out(ALU_result_out),
    .start(start), .stop_en(stop_en), .stop_pc(stop_pc),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_result(rd_result),
    .count(count), .overflow(overflow), .state(state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'hA000_0000 ^ pc;
  endfunction

  function automatic logic [31:0] result_of(input logic [31:0] pc);
    return 32'h5000_0000 + pc;
  endfunction

  task automatic set_pc(input logic [31:0] pc);
    current_PC      = pc;
    instruction_out = instr_of(pc);
    ALU_result_out  = result_of(pc);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] cap_pc [6];
    logic [4:0]  cap_cnt [6];
    logic [31:0] cap_rd [4];
    cap_pc  = '{32'h0, 32'h0, 32'h4, 32'h8, 32'h8, 32'hC};
    cap_cnt = '{5'd1, 5'd1, 5'd2, 5'd3, 5'd3, 5'd4};
    cap_rd  = '{32'h0, 32'h4, 32'h8, 32'hC};

    // reset with arbitrary inputs
    reset = 1'b1; start = 1'b0; stop_en = 1'b1; stop_pc = 32'h0; rd_ready = 1'b1;
    set_pc(32'hDEAD_BEEF);
    tick();
    chk("rst_state", state, 0);
    chk("rst_count", count, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_rd_pc", rd_pc, 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_pc(32'h100 * i);
      tick();
    end
    chk("idle_no_capture_count", count, 0);
    chk("idle_no_capture_state", state, 0);

    // capture with duplicate PCs filtered
    stop_en = 1'b0; rd_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("cap_state", state, 1);
    for (int i = 0; i < 6; i++) begin
      set_pc(cap_pc[i]);
      tick();
      chk("cap_count", count, cap_cnt[i]);
    end
    chk("cap_valid", rd_valid, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_ignored_count", count, 4);
    chk("start_ignored_state", state, 1);
    for (int i = 0; i < 4; i++) begin
      chk("cap_rd_pc", rd_pc, cap_rd[i]);
      chk("cap_rd_instr", rd_instr, instr_of(cap_rd[i]));
      chk("cap_rd_result", rd_result, result_of(cap_rd[i]));
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
    end
    chk("cap_drained_count", count, 0);
    chk("cap_drained_valid", rd_valid, 0);

    // breakpoint at 0x10
    do_reset();
    stop_en = 1'b1; stop_pc = 32'h10;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i <= 8; i++) begin
      set_pc(32'(4 * i));
      tick();
      if (i == 4) begin
        chk("bp_state", state, 2);
        chk("bp_count", count, 5);
      end
    end
    chk("bp_count_after", count, 5);
    chk("bp_state_after", state, 2);
    rd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rd_pc", rd_pc, 32'(4 * i));
      tick();
    end
    chk("bp_drain_count", count, 0);
    chk("bp_drain_state_hold", state, 2);
    tick();
    chk("bp_idle", state, 0);
    rd_ready = 1'b0;

    // overflow: 20 PCs into 16 slots, breakpoint on the 20th (dropped)
    stop_pc = 32'd20;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ovf_start_state", state, 1);
    for (int p = 1; p <= 20; p++) begin
      set_pc(32'(p));
      tick();
      if (p == 16) begin
        chk("ovf_full_count", count, 16);
        chk("ovf_not_yet", overflow, 0);
      end
      if (p == 17) chk("ovf_set", overflow, 1);
    end
    chk("ovf_count", count, 16);
    chk("ovf_flag", overflow, 1);
    chk("ovf_state", state, 2);
    rd_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      chk("ovf_rd_pc", rd_pc, 32'(k));
      tick();
    end
    rd_ready = 1'b0;
    chk("ovf_drained", count, 0);
    tick();
    chk("ovf_idle", state, 0);
    chk("ovf_sticky", overflow, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ovf_clr_count", count, 0);
    chk("ovf_clr_flag", overflow, 0);
    chk("ovf_clr_state", state, 1);

    // streaming push+pop, wraps pointers well past DEPTH
    stop_en = 1'b0; rd_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      set_pc(32'h100 + 32'(4 * i));
      tick();
      chk("stream_count", count, 1);
      chk("stream_rd_pc", rd_pc, 32'h100 + 32'(4 * i));
    end
    tick();
    chk("stream_empty", count, 0);
    rd_ready = 1'b0;

    // asynchronous reset mid-capture
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      set_pc(32'h40 + 32'(4 * i));
      tick();
    end
    chk("mid_count", count, 7);
    chk("mid_state", state, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_state", state, 0);
    chk("arst_count", count, 0);
    chk("arst_valid", rd_valid, 0);
    chk("arst_ovf", overflow, 0);
    chk("arst_rd_pc", rd_pc, 0);
    chk("arst_rd_instr", rd_instr, 0);
    tick();
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
